// File: rtl/plc_task_queue_pkg.sv
// Shared constants for the PLC task queue.
// RUN state code and default widths.
package plc_task_queue_pkg;
   localparam logic [1:0] PLC_RUN = 2'b01;
   localparam int unsigned TQ_IA_W = 12;
   localparam int unsigned TQ_AW = 4;
endpackage

// File: rtl/plc_task_queue_if.sv
// Task port between the bit CPU and the task queue.
// master = CPU side, slave = queue side.
interface plc_task_queue_if #(
   parameter int unsigned IA_W = 12,
   parameter int unsigned AW = 4
);
   logic [1:0] STATE;
   logic T_EN;
   logic T_WR;
   logic T_RD;
   logic [IA_W-1:0] T_O;
   logic [IA_W-1:0] T_I;
   logic T_RDY;
   logic DONE_B;
   logic EMPTY;
   logic FULL;
   logic [AW:0] COUNT;
   logic OVF;

   modport master (
      output STATE, T_EN, T_WR, T_RD, T_O,
      input T_I, T_RDY, DONE_B, EMPTY, FULL, COUNT, OVF
   );

   modport slave (
      input STATE, T_EN, T_WR, T_RD, T_O,
      output T_I, T_RDY, DONE_B, EMPTY, FULL, COUNT, OVF
   );
endinterface

// File: rtl/plc_fifo_ctl.sv
// Circular FIFO control: pointers, count, status and sticky overflow.
// Flush clears pointers/count but keeps OVF.
module plc_fifo_ctl #(
   parameter int unsigned AW = 4
) (
   input logic clk_i,
   input logic rst_ni,
   input logic flush_i,
   input logic push_req_i,
   input logic pop_req_i,
   output logic push_o,
   output logic pop_o,
   output logic [AW-1:0] wptr_o,
   output logic [AW-1:0] rptr_o,
   output logic [AW:0] count_o,
   output logic full_o,
   output logic empty_o,
   output logic ovf_o
);
   localparam logic [AW-1:0] PONE = {{(AW-1){1'b0}}, 1'b1};
   localparam logic [AW:0] CZERO = '0;

   logic [AW-1:0] wptr_q, wptr_d;
   logic [AW-1:0] rptr_q, rptr_d;
   logic [AW:0] count_q, count_d;
   logic ovf_q, ovf_d;

   assign full_o = count_q[AW];
   assign empty_o = (count_q == CZERO);
   assign push_o = push_req_i & ~full_o;
   assign pop_o = pop_req_i & ~empty_o;

   always_comb begin
      wptr_d = wptr_q;
      rptr_d = rptr_q;
      count_d = count_q;
      ovf_d = ovf_q;
      if (flush_i) begin
         wptr_d = '0;
         rptr_d = '0;
         count_d = '0;
      end else begin
         if (push_o) wptr_d = wptr_q + PONE;
         if (pop_o) rptr_d = rptr_q + PONE;
         count_d = count_q + {{AW{1'b0}}, push_o}
                           - {{AW{1'b0}}, pop_o};
         if (push_req_i & full_o) ovf_d = 1'b1;
      end
   end

   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         wptr_q <= '0;
         rptr_q <= '0;
         count_q <= '0;
         ovf_q <= 1'b0;
      end else begin
         wptr_q <= wptr_d;
         rptr_q <= rptr_d;
         count_q <= count_d;
         ovf_q <= ovf_d;
      end
   end

   assign wptr_o = wptr_q;
   assign rptr_o = rptr_q;
   assign count_o = count_q;
   assign ovf_o = ovf_q;
endmodule

// File: rtl/plc_task_queue.sv
// Task queue responder for the bit CPU task port.
// ADD_TASK pushes, GET_TASK pops into a registered T_I.
module plc_task_queue
   import plc_task_queue_pkg::*;
#(
   parameter int unsigned IA_W = TQ_IA_W,
   parameter int unsigned AW = TQ_AW
) (
   input logic CLK,
   input logic CLR,
   plc_task_queue_if.slave bus
);
   localparam int unsigned DEPTH = 2 ** AW;

   logic [IA_W-1:0] mem_q [DEPTH];
   logic [IA_W-1:0] t_i_q, t_i_d;
   logic done_b_q, done_b_d;

   logic flush;
   logic push_req, pop_req;
   logic push, pop;
   logic [AW-1:0] wptr, rptr;
   logic empty;

   assign flush = (bus.STATE != PLC_RUN);
   assign push_req = bus.T_EN & bus.T_WR;
   assign pop_req = bus.T_EN & bus.T_RD;

   plc_fifo_ctl #(.AW(AW)) u_ctl (
      .clk_i (CLK),
      .rst_ni (CLR),
      .flush_i (flush),
      .push_req_i (push_req),
      .pop_req_i (pop_req),
      .push_o (push),
      .pop_o (pop),
      .wptr_o (wptr),
      .rptr_o (rptr),
      .count_o (bus.COUNT),
      .full_o (bus.FULL),
      .empty_o (empty),
      .ovf_o (bus.OVF)
   );

   // Storage is never reset; contents are don't-care while empty.
   always_ff @(posedge CLK) begin
      if (CLR && !flush && push) mem_q[wptr] <= bus.T_O;
   end

   always_comb begin
      t_i_d = t_i_q;
      done_b_d = done_b_q;
      if (flush) begin
         t_i_d = '0;
         done_b_d = 1'b0;
      end else begin
         if (pop) t_i_d = mem_q[rptr];
         // A push always releases a waiting GET.
         if (push) done_b_d = 1'b0;
         else if (pop_req & empty) done_b_d = 1'b1;
      end
   end

   always_ff @(posedge CLK) begin
      if (!CLR) begin
         t_i_q <= '0;
         done_b_q <= 1'b0;
      end else begin
         t_i_q <= t_i_d;
         done_b_q <= done_b_d;
      end
   end

   assign bus.T_I = t_i_q;
   assign bus.DONE_B = done_b_q;
   assign bus.EMPTY = empty;
   assign bus.T_RDY = pop_req ? ~empty : 1'b1;
endmodule
